// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_AW     = 5;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/acknowledge link between the sequencer and the data memory.
interface pipe_ctrl_if;

  logic        dmem_req;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare between the load in ID/EX and the sources in IF/ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic              memread_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              load_use_o
);

  // x0 is never written, so a load targeting it cannot create a hazard.
  assign load_use_o = memread_i && (rd_i != '0) &&
                      ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: memory handshake FSM, hazard priority, counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  input  logic              branch_taken_i,
  input  logic              exmem_mem_i,
  pipe_ctrl_if.master       dmem,
  output logic [31:0]       mem_rdata_o,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              idex_we_o,
  output logic              exmem_we_o,
  output logic              memwb_we_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]            mem_rdata_q, mem_rdata_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic                   load_use;

  hazard_detect u_hazard_detect (
    .memread_i  (idex_memread_i),
    .rd_i       (idex_rd_i),
    .rs1_i      (ifid_rs1_i),
    .rs2_i      (ifid_rs2_i),
    .load_use_o (load_use)
  );

  // Request is a pure state decode so reset removes it without a clock edge.
  assign dmem.dmem_req = (state_q == WAIT);
  assign mem_rdata_o   = mem_rdata_q;
  assign err_o         = err_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

  // Next state and stage controls; memory stall beats load-use beats branch.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    mem_rdata_d  = mem_rdata_q;
    err_d        = err_q;
    pc_we_o      = 1'b1;
    ifid_we_o    = 1'b1;
    idex_we_o    = 1'b1;
    exmem_we_o   = 1'b1;
    memwb_we_o   = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;

    case (state_q)
      RUN: begin
        if (exmem_mem_i) begin
          pc_we_o    = 1'b0;
          ifid_we_o  = 1'b0;
          idex_we_o  = 1'b0;
          exmem_we_o = 1'b0;
          memwb_we_o = 1'b0;
          state_d    = WAIT;
        end else if (load_use) begin
          pc_we_o      = 1'b0;
          ifid_we_o    = 1'b0;
          idex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
        end
      end
      WAIT: begin
        pc_we_o    = 1'b0;
        ifid_we_o  = 1'b0;
        idex_we_o  = 1'b0;
        exmem_we_o = 1'b0;
        memwb_we_o = 1'b0;
        wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        if (dmem.dmem_ack) begin
          mem_rdata_d = dmem.dmem_rdata;
          state_d     = DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_rdata_d = '0;
          err_d       = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (load_use) begin
          pc_we_o      = 1'b0;
          ifid_we_o    = 1'b0;
          idex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
        end
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating event counters driven by the enables chosen above.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State and Moore output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It owns the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It performs load-use hazard detection and branch flushing, and runs the req/ack handshake with a variable-latency data memory. It also latches load data for MEM/WB and keeps saturating stall/flush counters.

## Interface
- CNT_W, 16: width of stall and flush counters
- MEM_TIMEOUT, 255: maximum cycles spent in WAIT before abort, range 1..255
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- idex_memread_i  in  1  instruction in ID/EX is a load
- idex_rd_i  in  5  destination register of the ID/EX instruction
- ifid_rs1_i, ifid_rs2_i  in  5 each  source registers of the IF/ID instruction
- branch_taken_i  in  1  branch resolved taken in ID
- exmem_mem_i  in  1  instruction in EX/MEM accesses data memory (load or store)
- dmem_ack_i  in  1  data memory done; dmem_rdata_i valid this cycle
- dmem_rdata_i  in  32  data memory read data
- dmem_req_o  out  1  data memory request; address and write-enable come directly from EX/MEM
- mem_rdata_o  out  32  latched read data, feeds MEM/WB MemRdata input
- pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o  out  1 each  stage register enables
- ifid_flush_o, idex_flush_o  out  1 each  load zeros (bubble) into the stage register
- err_o  out  1  sticky memory-timeout flag
- stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating counters

## Operation
- FSM states:
  - RUN: reset state.
    - exmem_mem_i=1: all we=0, both flushes 0, go to WAIT.
    - Otherwise: hazard logic applies.
  - WAIT:
    - Outputs: dmem_req_o=1, all we=0, both flushes 0, wait counter increments.
    - dmem_ack_i=1: mem_rdata_o <= dmem_rdata_i, go to DONE.
    - Wait counter reaches MEM_TIMEOUT without ack: mem_rdata_o <= 0, err_o <= 1, go to DONE.
  - DONE:
    - Behaves like RUN, except exmem_mem_i is ignored (it is the instruction just served).
    - Always returns to RUN.
- Hazard logic, active in RUN (no memory access) and in DONE:
  - Load-use: idex_memread_i && idex_rd_i!=0 && (idex_rd_i==ifid_rs1_i || idex_rd_i==ifid_rs2_i).
  - Load-use result: pc_we_o=0, ifid_we_o=0, idex_flush_o=1; idex/exmem/memwb we=1.
  - Otherwise, if branch_taken_i: ifid_flush_o=1, all we=1.
  - Otherwise: all we=1, no flushes.
- Priority: memory stall > load-use > branch. A branch is ignored under load-use because its operands are stale; it re-resolves next cycle.
- Counters:
  - stall_cnt_o increments every cycle pc_we_o=0.
  - flush_cnt_o increments every cycle ifid_flush_o=1.
  - Both saturate at all-ones and never wrap.
- Stores use the same handshake; mem_rdata_o is latched but unused downstream.

## Timing
- Moore outputs: dmem_req_o, err_o, mem_rdata_o, counters. Stage enables and flushes are combinational from state and inputs.
- Reset values:
  - state=RUN, dmem_req_o=0, mem_rdata_o=0, err_o=0, counters=0, wait counter=0.
  - Enables/flushes then follow RUN logic from inputs.
- Memory access with exmem_mem_i=1 in cycle t:
  - t: stall.
  - t+1: WAIT with req=1.
  - Ack in t+1: DONE in t+2, where all stages advance and MEM/WB captures mem_rdata_o.
  - Minimum cost is 2 stall cycles. Ack after k WAIT cycles costs k+1.
- Ack in the same cycle the timeout expires: ack wins, err_o unchanged.
- Back-to-back memory instructions: the next one enters EX/MEM at the DONE edge and is detected in the following RUN cycle.
- dmem_ack_i outside WAIT is ignored.
- Reset mid-WAIT: dmem_req_o drops asynchronously and the transaction is abandoned.
- Load-use and a taken branch in DONE are honoured exactly as in RUN.

## Structure
- pipe_ctrl_pkg:
  - state enum {RUN, WAIT, DONE}.
  - Register-index width constant REG_AW=5.
- Sub-module hazard_detect: combinational load-use compare, instantiated once.
- Wait counter: 8 bits.

## Test plan
- Reset, then exmem_mem_i=0 and no hazards: all we=1, flushes 0, dmem_req_o=0, counters 0.
- Load-use with idex_rd_i=5, ifid_rs2_i=5, branch_taken_i=1: pc_we_o=ifid_we_o=0, idex_flush_o=1, ifid_flush_o=0, stall_cnt_o=1. Repeat with idex_rd_i=0: no stall.
- Load in MEM, ack in 3rd WAIT cycle with rdata 0xDEADBEEF: 4 stall cycles, DONE shows mem_rdata_o=0xDEADBEEF and all we=1.
- MEM_TIMEOUT=4, no ack: req high exactly 4 cycles, then err_o=1 (sticky) and mem_rdata_o=0. Repeat with ack on the 4th cycle: err_o stays 0.
- Assert rst_i=0 during WAIT: dmem_req_o falls without a clock edge, state=RUN after release.
- CNT_W=4 with 20 forced stalls: stall_cnt_o holds at 15.
